// File: rtl/jelly_unsigned_sum_of_squares_multicycle.sv
// Multicycle sum-of-squares accumulator.
// Each accepted sample is squared with a shift-add multiplier that retires
// one multiplier bit per cycle. The squares add into a wide accumulator that
// has headroom plus a sticky carry. On the last sample of a frame, the sum is
// right-shifted, saturated to 2*DATA_WIDTH bits and presented downstream.
module jelly_unsigned_sum_of_squares_multicycle #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 8,
  parameter int SHIFT       = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cke,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_last,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [2*DATA_WIDTH-1:0] m_data,
  output logic                    m_overflow,
  output logic                    m_valid,
  input  logic                    m_ready
);

  localparam int OW   = 2 * DATA_WIDTH;
  localparam int AW   = OW + COUNT_WIDTH;
  localparam int CNTW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic                last_q, last_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic                carry_q, carry_d;
  logic                s_ready_q, s_ready_d;
  logic                m_valid_q, m_valid_d;
  logic [OW-1:0]       m_data_q, m_data_d;
  logic                m_overflow_q, m_overflow_d;

  // Datapath helpers: this cycle's partial product and the post-add accumulator
  logic [AW-1:0] addend;
  logic [AW-1:0] acc_mul;
  logic          carry_out;
  logic          carry_mul;
  logic [AW-1:0] shifted;
  logic          sat;
  logic          accept;
  logic          mul_done;

  assign accept   = s_valid && s_ready_q;
  assign mul_done = (cnt_q == CNTW'(DATA_WIDTH - 1));

  assign addend              = mplier_q[0] ? (AW'(mcand_q) << cnt_q) : '0;
  assign {carry_out, acc_mul} = {1'b0, acc_q} + {1'b0, addend};
  assign carry_mul           = carry_q | carry_out;
  assign shifted             = acc_mul >> SHIFT;
  // Any set bit above the output width, or a lost carry, forces saturation.
  assign sat                 = carry_mul | (|shifted[AW-1:OW]);

  // State register; cke freezes the whole machine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else if (cke) begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)             state_d = ST_MUL;
      ST_MUL:  if (mul_done)           state_d = last_q ? ST_OUT : ST_IDLE;
      ST_OUT:  if (m_valid_q && m_ready) state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    carry_d      = carry_q;
    m_data_d     = m_data_q;
    m_overflow_d = m_overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mcand_d  = s_data;
          mplier_d = s_data;
          last_d   = s_last;
          cnt_d    = '0;
        end
      end
      ST_MUL: begin
        acc_d    = acc_mul;
        carry_d  = carry_mul;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNTW'(1);
        if (mul_done && last_q) begin
          m_data_d     = sat ? '1 : shifted[OW-1:0];
          m_overflow_d = sat;
        end
      end
      ST_OUT: begin
        // Frame consumed: clear the sum so the next frame starts fresh.
        if (m_valid_q && m_ready) begin
          acc_d   = '0;
          carry_d = 1'b0;
        end
      end
      default: ;
    endcase
    s_ready_d = (state_d == ST_IDLE);
    m_valid_d = (state_d == ST_OUT);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q      <= '0;
      mplier_q     <= '0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      carry_q      <= 1'b0;
      s_ready_q    <= 1'b1;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_overflow_q <= 1'b0;
    end else if (cke) begin
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      carry_q      <= carry_d;
      s_ready_q    <= s_ready_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_overflow_q <= m_overflow_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_overflow = m_overflow_q;

endmodule
